// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with storage, pointer/flag control,
// level count, almost-full/almost-empty thresholds, sticky error flags and
// a selectable registered or first-word-fall-through read port.
module sync_fifo_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH),
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             W_EN,
    input  logic [WIDTH-1:0] W_DI,
    input  logic             R_EN,
    output logic [WIDTH-1:0] R_DO,
    output logic             R_VALID,
    output logic             FULL,
    output logic             EMPTY,
    output logic             AFULL,
    output logic             AEMPTY,
    output logic [AW:0]      COUNT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW,
    input  logic             CLR_ERR
);

    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;

    // Flags come only from the registered pointers, so no input reaches them.
    assign empty  = (wptr == rptr);
    assign full   = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign count  = wptr - rptr;

    // Accepts are judged against the state at the start of the cycle; a
    // rejected side never touches memory or pointers.
    assign wr_acc = W_EN && !full;
    assign rd_acc = R_EN && !empty;

    assign FULL   = full;
    assign EMPTY  = empty;
    assign COUNT  = count;
    assign AFULL  = (count >= AFULL_C);
    assign AEMPTY = (count <= AEMPTY_C);

    // Pointer update; the MSB acts as the wrap bit and wraps naturally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + PTR_ONE;
            if (rd_acc) rptr <= rptr + PTR_ONE;
        end
    end

    // Storage array; contents survive reset, writes during reset are dropped.
    always_ff @(posedge CLK) begin
        if (wr_acc && !RST) mem[wptr[AW-1:0]] <= W_DI;
    end

    // Sticky error flags; a new error in the clearing cycle wins over CLR_ERR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (W_EN && full)  OVERFLOW <= 1'b1;
            else if (CLR_ERR)  OVERFLOW <= 1'b0;
            if (R_EN && empty) UNDERFLOW <= 1'b1;
            else if (CLR_ERR)  UNDERFLOW <= 1'b0;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [WIDTH-1:0] r_do_q;
            logic             r_valid_q;

            // Registered read: data appears the cycle after the accepted read,
            // valid pulses for one cycle, data holds otherwise.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_do_q    <= '0;
                    r_valid_q <= 1'b0;
                end else begin
                    r_valid_q <= rd_acc;
                    if (rd_acc) r_do_q <= mem[rptr[AW-1:0]];
                end
            end

            assign R_DO    = r_do_q;
            assign R_VALID = r_valid_q;
        end else begin : g_fwft_read
            // Head word is shown directly; R_EN acknowledges and advances it.
            assign R_DO    = mem[rptr[AW-1:0]];
            assign R_VALID = !empty;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: one registered-read and one FWFT instance driven
// by identical stimulus, both compared against a queue-based model.
module tb_sync_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             w_en = 1'b0;
    logic [WIDTH-1:0] w_di = '0;
    logic             r_en = 1'b0;
    logic             clr_err = 1'b0;

    logic [WIDTH-1:0] r_do0, r_do1;
    logic             r_valid0, r_valid1;
    logic             full0, empty0, afull0, aempty0, ovf0, unf0;
    logic             full1, empty1, afull1, aempty1, ovf1, unf1;
    logic [AW:0]      count0, count1;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;
    logic             m_rvalid0 = 1'b0;
    logic [WIDTH-1:0] m_rdo0 = '0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) dut_reg (
        .CLK(clk), .RST(rst), .W_EN(w_en), .W_DI(w_di), .R_EN(r_en),
        .R_DO(r_do0), .R_VALID(r_valid0), .FULL(full0), .EMPTY(empty0),
        .AFULL(afull0), .AEMPTY(aempty0), .COUNT(count0),
        .OVERFLOW(ovf0), .UNDERFLOW(unf0), .CLR_ERR(clr_err)
    );

    sync_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
        .CLK(clk), .RST(rst), .W_EN(w_en), .W_DI(w_di), .R_EN(r_en),
        .R_DO(r_do1), .R_VALID(r_valid1), .FULL(full1), .EMPTY(empty1),
        .AFULL(afull1), .AEMPTY(aempty1), .COUNT(count1),
        .OVERFLOW(ovf1), .UNDERFLOW(unf1), .CLR_ERR(clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: apply the FIFO rules to the pre-edge model state.
    task automatic model_update(input bit w, input logic [WIDTH-1:0] d,
                                input bit r, input bit c, input bit rs);
        bit was_full, was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (rs) begin
            q.delete();
            m_ovf = 1'b0; m_unf = 1'b0;
            m_rvalid0 = 1'b0; m_rdo0 = '0;
        end else begin
            if (r && !was_empty) begin
                m_rdo0 = q.pop_front();
                m_rvalid0 = 1'b1;
            end else begin
                m_rvalid0 = 1'b0;
            end
            if (w && !was_full) q.push_back(d);
            if (w && was_full) m_ovf = 1'b1;
            else if (c)        m_ovf = 1'b0;
            if (r && was_empty) m_unf = 1'b1;
            else if (c)         m_unf = 1'b0;
        end
    endtask

    task automatic check_all(input string ph);
        int n;
        n = q.size();
        chk({ph, "_count0"}, 32'(count0), 32'(n));
        chk({ph, "_count1"}, 32'(count1), 32'(n));
        chk({ph, "_empty"},  {30'd0, empty0, empty1},   {30'd0, n == 0, n == 0});
        chk({ph, "_full"},   {30'd0, full0, full1},     {30'd0, n == DEPTH, n == DEPTH});
        chk({ph, "_afull"},  {30'd0, afull0, afull1},   {30'd0, n >= DEPTH-2, n >= DEPTH-2});
        chk({ph, "_aempty"}, {30'd0, aempty0, aempty1}, {30'd0, n <= 2, n <= 2});
        chk({ph, "_ovf"},    {30'd0, ovf0, ovf1},       {30'd0, m_ovf, m_ovf});
        chk({ph, "_unf"},    {30'd0, unf0, unf1},       {30'd0, m_unf, m_unf});
        chk({ph, "_rvalid0"}, 32'(r_valid0), 32'(m_rvalid0));
        chk({ph, "_rdo0"},    32'(r_do0),    32'(m_rdo0));
        chk({ph, "_rvalid1"}, 32'(r_valid1), 32'(n != 0));
        if (n != 0) chk({ph, "_rdo1"}, 32'(r_do1), 32'(q[0]));
    endtask

    // One clock: drive inputs, advance model at the edge, sample 1 ns later.
    task automatic step(input string ph, input bit w, input logic [WIDTH-1:0] d,
                        input bit r, input bit c, input bit rs);
        w_en = w; w_di = d; r_en = r; clr_err = c; rst = rs;
        @(posedge clk);
        model_update(w, d, r, c, rs);
        #1;
        check_all(ph);
    endtask

    initial begin
        int wp;
        // Reset state
        step("reset", 0, 8'h00, 0, 0, 1);
        chk("reset_rdo0_zero", 32'(r_do0), 32'h0);

        // Fill with 0x00..0x0F
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 8'(i), 0, 0, 0);
        chk("fill_full_const", 32'(full0), 32'h1);

        // Write while full: rejected, overflow set
        step("ovf_write", 1, 8'hEE, 0, 0, 0);
        chk("ovf_const", 32'(ovf0), 32'h1);
        step("clr1", 0, 8'h00, 0, 1, 0);

        // Drain in order; 0xEE must never appear
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 0, 8'h00, 1, 0, 0);
            chk("drain_order_const", 32'(r_do0), 32'(i));
        end

        // Read while empty
        step("unf_read", 0, 8'h00, 1, 0, 0);
        chk("unf_const", {31'd0, unf0}, 32'h1);
        step("clr2", 0, 8'h00, 0, 1, 0);
        chk("clr_const", {30'd0, ovf0, unf0}, 32'h0);

        // Fall-through head visibility
        step("fwft_a5", 1, 8'hA5, 0, 0, 0);
        chk("fwft_a5_const", {23'd0, r_valid1, r_do1}, {23'd0, 1'b1, 8'hA5});
        step("fwft_3c", 1, 8'h3C, 1, 0, 0);
        chk("fwft_3c_const", {19'd0, count1, r_do1}, {19'd0, 5'd1, 8'h3C});
        step("fwft_pop", 0, 8'h00, 1, 0, 0);

        // Simultaneous read/write at COUNT=5 for 40 cycles
        for (int i = 0; i < 5; i++) step("pre5", 1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 40; i++) step("rw5", 1, 8'($urandom), 1, 0, 0);
        chk("rw5_count_const", 32'(count0), 32'd5);

        // Fill to full, then simultaneous R/W at full
        for (int i = 0; i < 11; i++) step("top", 1, 8'($urandom), 0, 0, 0);
        step("rw_full", 1, 8'h77, 1, 0, 0);
        chk("rw_full_count_const", 32'(count0), 32'd15);
        step("clr3", 0, 8'h00, 0, 1, 0);
        step("refill", 1, 8'h55, 0, 0, 0);
        // New overflow coincident with CLR_ERR keeps the flag
        step("ovf_clr", 1, 8'h99, 0, 1, 0);
        chk("ovf_clr_const", 32'(ovf0), 32'h1);

        // Empty with W_EN & R_EN: write accepted, read rejected
        for (int i = 0; i < DEPTH; i++) step("drain2", 0, 8'h00, 1, 1, 0);
        step("rw_empty", 1, 8'h42, 1, 0, 0);
        chk("rw_empty_const", {26'd0, unf0, count0}, {26'd0, 1'b1, 5'd1});

        // Randomized traffic, alternating write-heavy and read-heavy phases
        for (int i = 0; i < 400; i++) begin
            wp = ((i / 50) % 2 == 0) ? 75 : 25;
            step("rand", $urandom_range(0, 99) < wp, 8'($urandom),
                 $urandom_range(0, 99) >= wp, $urandom_range(0, 19) == 0, 0);
        end

        // Reset mid-stream at COUNT=9
        step("pre_rst_clr", 0, 8'h00, 0, 1, 1);
        for (int i = 0; i < 9; i++) step("fill9", 1, 8'($urandom), 0, 0, 0);
        step("rst_mid", 1, 8'hFF, 1, 0, 1);
        chk("rst_mid_const", {25'd0, count0, empty0, r_valid0, ovf0, unf0},
            {25'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        step("post_rst", 0, 8'h00, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock, parametrised FIFO combining storage, pointer/flag control and error reporting in one block. It succeeds the bare FIFO memory array, which needed external pointers and flags. It adds a level count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, and a selectable read mode: registered output or first-word-fall-through (FWFT). It sits between any producer/consumer pair in the same clock domain, e.g. UART RX/TX buffering and bus-bridge staging.

## Interface
Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of entries; power of two, ≥ 2.
- AW, $clog2(DEPTH): address width; pointers are AW+1 bits (MSB = wrap bit).
- FWFT, 0: 0 = registered read, 1 = first-word-fall-through.
- AFULL_TH, DEPTH-2: AFULL asserted when COUNT ≥ AFULL_TH.
- AEMPTY_TH, 2: AEMPTY asserted when COUNT ≤ AEMPTY_TH.

Ports:
- CLK  in  1  sole clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- W_EN  in  1  write request.
- W_DI  in  WIDTH  write data.
- R_EN  in  1  read request (FWFT: pop/acknowledge of the head word).
- R_DO  out  WIDTH  read data.
- R_VALID  out  1  R_DO holds valid data.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- AFULL  out  1  almost full.
- AEMPTY  out  1  almost empty.
- COUNT  out  AW+1  stored word count, 0..DEPTH.
- OVERFLOW  out  1  sticky: write attempted while FULL.
- UNDERFLOW  out  1  sticky: read attempted while EMPTY.
- CLR_ERR  in  1  clears OVERFLOW/UNDERFLOW.

## Operation
- **Write accept** = W_EN & !FULL. Store W_DI at mem[wptr[AW-1:0]] and increment wptr.
- **Read accept** = R_EN & !EMPTY. Increment rptr.
- FULL and EMPTY are evaluated from state at the start of the cycle. There is no pass-through: a write to an empty FIFO cannot be read in the same cycle.
- **Simultaneous accept:**
  - Both read and write accepted: COUNT unchanged, both pointers advance.
  - FIFO full with W_EN & R_EN: the read is accepted, the write is rejected, and OVERFLOW is set.
  - FIFO empty with W_EN & R_EN: the write is accepted, the read is rejected, and UNDERFLOW is set.
- **Flag derivation:**
  - EMPTY when wptr == rptr.
  - FULL when the low AW bits are equal and the MSBs differ.
  - COUNT = wptr − rptr, modulo 2^(AW+1).
  - Pointers wrap naturally; no special handling at DEPTH.
- **FWFT=0 (registered read):**
  - On read accept, R_DO <= mem[rptr] and R_VALID <= 1 for exactly one cycle.
  - When no read is accepted, R_VALID <= 0 and R_DO holds its last value.
- **FWFT=1 (fall-through read):**
  - R_DO = mem[rptr[AW-1:0]] combinationally.
  - R_VALID = !EMPTY.
  - R_DO is don't-care while R_VALID = 0.
  - R_EN acknowledges the displayed word; the next word appears after the edge.
- **Error flags:**
  - OVERFLOW sets on W_EN & FULL; UNDERFLOW sets on R_EN & EMPTY.
  - Both clear on CLR_ERR.
  - If a set event and CLR_ERR occur in the same cycle, the flag stays set.
  - Rejected operations never modify memory, pointers or COUNT.
- **Thresholds:** AFULL and AEMPTY are registered, or derived from registered COUNT, and always consistent with COUNT in the same cycle.

## Timing
- **Reset values** (RST high at an edge):
  - wptr = rptr = 0, COUNT = 0.
  - EMPTY = 1, FULL = 0, AEMPTY = 1, AFULL = 0, OVERFLOW = 0, UNDERFLOW = 0.
  - FWFT=0: R_VALID = 0 and R_DO = 0.
  - Memory contents are not reset.
- **Reset mid-operation:** all in-flight data is discarded. W_EN/R_EN in the reset cycle are ignored and set no error flags.
- **Write-to-flag latency:** 1 cycle. After the accepting edge, EMPTY = 0 and COUNT is incremented.
- **Read latency:**
  - FWFT=0: R_DO/R_VALID are valid in the cycle after the accepting edge.
  - FWFT=1: the head word is visible one cycle after the first write into an empty FIFO.
- **Throughput:** one write and one read per cycle, sustained, at any fill level 0 < COUNT < DEPTH.
- All outputs except FWFT-mode R_DO/R_VALID are driven from registers or from register-only logic (no input-to-output combinational paths).

## Test plan
- **Reset then fill:** RST, then 16 writes of 0x00..0x0F (DEPTH=16). Expect:
  - COUNT steps 0→16.
  - AFULL asserts at COUNT = 14.
  - FULL at 16, EMPTY deasserts after the first write.
  - No error flags set.
- **Drain in order, FWFT=0:** 16 reads. Expect:
  - R_DO = 0x00..0x0F, each one cycle after its R_EN.
  - R_VALID one cycle wide per read.
  - EMPTY after the last read; AEMPTY once COUNT ≤ 2.
- **Overflow/underflow:**
  - W_EN while full: memory unchanged, OVERFLOW = 1.
  - R_EN while empty: UNDERFLOW = 1, COUNT stays 0.
  - CLR_ERR for one cycle: both flags clear.
  - CLR_ERR coincident with a new overflow: OVERFLOW stays 1.
- **Simultaneous R/W:**
  - At COUNT = 5: W_EN & R_EN for 40 cycles. COUNT stays 5, pointers wrap at least twice, output order is preserved.
  - At full: the read is accepted and the write is rejected.
- **FWFT=1:**
  - Write 0xA5 into an empty FIFO: the next cycle shows R_VALID = 1, R_DO = 0xA5.
  - Then write 0x3C and assert R_EN: the next cycle shows R_DO = 0x3C, COUNT = 1.
- **Reset mid-stream:**
  - Fill to COUNT = 9, assert RST together with W_EN & R_EN.
  - Next cycle: COUNT = 0, EMPTY = 1, R_VALID = 0, error flags 0.
